decode_issue_ctrl: RTL and testbench

- Decode-stage sequencer between fetch and execute.
- Accepts fetched {instr, pc} beats over a valid/ready handshake and buffers them in an output register plus one skid entry.
- Generates the sign-extended immediate and format class per beat; presents one decoded beat per cycle to execute.
- Handles load-use hazard bubbles, branch/jump flush and backpressure without losing or duplicating instructions.

---
 rtl/decode_pkg.sv | 42 ++++
 rtl/imm_fmt_decode.sv | 54 +++++
 rtl/decode_issue_ctrl.sv | 152 +++++++++++++++
 tb/tb_decode_issue_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared types for the decode/issue stage: format classes, opcodes, buffered beat layout.
package decode_pkg;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_e;

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_FULL      = 2'd1,
    ST_FULL_SKID = 2'd2
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  localparam int DEC_XLEN = 32;
  localparam int DEC_PC_W = 32;

  typedef struct packed {
    logic [31:0]         instr;
    logic [DEC_PC_W-1:0] pc;
    logic [DEC_XLEN-1:0] imm;
    fmt_e                fmt;
    logic                illegal;
  } dec_beat_t;

endpackage

// File: rtl/imm_fmt_decode.sv
// Combinational instruction classifier: immediate, format class, legality and source-register usage.
import decode_pkg::*;

module imm_fmt_decode (
  input  logic [31:0] instr,
  output logic [31:0] imm,
  output fmt_e        fmt,
  output logic        illegal,
  output logic        uses_rs1,
  output logic        uses_rs2
);

  always_comb begin
    imm      = '0;
    fmt      = FMT_NONE;
    illegal  = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (instr[6:0])
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: begin
        imm      = {{20{instr[31]}}, instr[31:20]};
        fmt      = FMT_I;
        uses_rs1 = 1'b1;
      end
      OP_STORE: begin
        imm      = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        fmt      = FMT_S;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        imm      = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        fmt      = FMT_B;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        imm = {instr[31:12], 12'b0};
        fmt = FMT_U;
      end
      OP_JAL: begin
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        fmt = FMT_J;
      end
      OP_REG: begin
        fmt      = FMT_R;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_issue_ctrl.sv
// Decode-stage sequencer: output register + one skid entry, load-use bubbles, flush.
// Optional DECODE_PERF_CNT_EN enables the stall/backpressure performance counters.
import decode_pkg::*;

module decode_issue_ctrl #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [PC_W-1:0] if_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_instr,
  output logic [PC_W-1:0] id_pc,
  output logic [XLEN-1:0] id_imm,
  output fmt_e            id_fmt,
  output logic            id_illegal,
  input  logic            flush,
  input  logic            ex_load_valid,
  input  logic [4:0]      ex_load_rd,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_bp_cnt
);

  state_e      state_q, state_d;
  dec_beat_t   out_q, out_d, skid_q, skid_d, in_beat;
  logic [1:0]  out_use_q, out_use_d, skid_use_q, skid_use_d, in_use;
  logic        if_ready_q, if_ready_d;
  logic [31:0] dec_imm;
  fmt_e        dec_fmt;
  logic        dec_illegal, dec_rs1, dec_rs2;
  logic        out_vld, accept, fire, hazard;

  imm_fmt_decode u_dec (
    .instr    (if_instr),
    .imm      (dec_imm),
    .fmt      (dec_fmt),
    .illegal  (dec_illegal),
    .uses_rs1 (dec_rs1),
    .uses_rs2 (dec_rs2)
  );

  assign in_beat = '{instr: if_instr, pc: DEC_PC_W'(if_pc), imm: dec_imm,
                     fmt: dec_fmt, illegal: dec_illegal};
  assign in_use  = {dec_rs2, dec_rs1};

  assign out_vld = (state_q != ST_EMPTY);
  assign hazard  = out_vld & ex_load_valid & (ex_load_rd != 5'd0) &
                   ((out_use_q[0] & (out_q.instr[19:15] == ex_load_rd)) |
                    (out_use_q[1] & (out_q.instr[24:20] == ex_load_rd)));
  assign accept  = if_valid & if_ready_q;
  assign fire    = id_valid & id_ready;

  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    skid_d     = skid_q;
    out_use_d  = out_use_q;
    skid_use_d = skid_use_q;
    if (flush) begin
      // Anything buffered or arriving this cycle belongs to the squashed path.
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d   = ST_FULL;
            out_d     = in_beat;
            out_use_d = in_use;
          end
        end
        ST_FULL: begin
          if (accept && fire) begin
            out_d     = in_beat;
            out_use_d = in_use;
          end else if (accept) begin
            state_d    = ST_FULL_SKID;
            skid_d     = in_beat;
            skid_use_d = in_use;
          end else if (fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL_SKID: begin
          if (fire) begin
            state_d   = ST_FULL;
            out_d     = skid_q;
            out_use_d = skid_use_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    if_ready_d = (state_d != ST_FULL_SKID);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      out_q      <= '0;
      skid_q     <= '0;
      out_use_q  <= '0;
      skid_use_q <= '0;
      if_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
      out_use_q  <= out_use_d;
      skid_use_q <= skid_use_d;
      if_ready_q <= if_ready_d;
    end
  end

  assign if_ready   = if_ready_q;
  assign id_valid   = out_vld & ~hazard;
  assign id_instr   = out_q.instr;
  assign id_pc      = PC_W'(out_q.pc);
  assign id_imm     = XLEN'(signed'(out_q.imm));
  assign id_fmt     = out_q.fmt;
  assign id_illegal = out_q.illegal;

`ifdef DECODE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, bp_cnt_q, bp_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, hazard};
    bp_cnt_d    = bp_cnt_q + {31'd0, id_valid & ~id_ready};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      bp_cnt_q    <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      bp_cnt_q    <= bp_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_bp_cnt    = bp_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_bp_cnt    = '0;
`endif

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Scoreboard bench for decode_issue_ctrl: driver queues expected beats, negedge monitor checks them.
import decode_pkg::*;

module tb_decode_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst, if_valid, if_ready, id_valid, id_ready, id_illegal, flush, ex_load_valid;
  logic [31:0] if_instr, if_pc, id_instr, id_pc, id_imm, perf_stall_cnt, perf_bp_cnt;
  logic [4:0]  ex_load_rd;
  fmt_e        id_fmt;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  exp_t cur;
  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  logic [31:0] bp0;

`ifdef DECODE_PERF_CNT_EN
  localparam logic [31:0] EXP_STALL = 32'd3;
  localparam logic [31:0] EXP_BP    = 32'd4;
`else
  localparam logic [31:0] EXP_STALL = 32'd0;
  localparam logic [31:0] EXP_BP    = 32'd0;
`endif

  always #5 clk = ~clk;

  decode_issue_ctrl #(.XLEN(32), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc), .id_imm(id_imm), .id_fmt(id_fmt),
    .id_illegal(id_illegal), .flush(flush), .ex_load_valid(ex_load_valid),
    .ex_load_rd(ex_load_rd), .perf_stall_cnt(perf_stall_cnt), .perf_bp_cnt(perf_bp_cnt)
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end else begin
      $display("check %s: %h ok", nm, act);
    end
  endfunction

  // Monitor/scoreboard: pops on every fire, pushes on every accept, drops on flush/reset.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb_q.delete();
    end else begin
      if (id_valid && id_ready) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: got instr=%h pc=%h, expected no beat", id_instr, id_pc);
        end else begin
          e = sb_q.pop_front();
          if ({id_instr, id_pc, id_imm, 3'(id_fmt), id_illegal} !== {e.instr, e.pc, e.imm, e.fmt, e.ill}) begin
            n_fail++;
            $display("FAIL beat: got instr=%h pc=%h imm=%h fmt=%0d ill=%b, expected instr=%h pc=%h imm=%h fmt=%0d ill=%b",
                     id_instr, id_pc, id_imm, id_fmt, id_illegal, e.instr, e.pc, e.imm, e.fmt, e.ill);
          end else begin
            $display("beat instr=%h pc=%h imm=%h fmt=%0d ill=%b ok", id_instr, id_pc, id_imm, id_fmt, id_illegal);
          end
        end
      end
      if (flush) sb_q.delete();
      else if (if_valid && if_ready) sb_q.push_back(cur);
    end
  end

  task automatic present(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [2:0] fmt, input logic ill);
    cur      = '{instr: instr, pc: pc, imm: imm, fmt: fmt, ill: ill};
    if_instr = instr;
    if_pc    = pc;
    if_valid = 1'b1;
  endtask

  task automatic wait_accept();
    int guard = 0;
    @(negedge clk);
    while (!if_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!if_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: got if_ready=0, expected 1 within 40 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] imm,
                      input logic [2:0] fmt, input logic ill);
    present(instr, pc, imm, fmt, ill);
    wait_accept();
  endtask

  task automatic idle(input int n);
    if_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0; id_ready = 1'b0;
    flush = 1'b0; ex_load_valid = 1'b0; ex_load_rd = '0;
    cur = '{instr: 0, pc: 0, imm: 0, fmt: 0, ill: 0};
    repeat (3) @(negedge clk);
    chk("rst_if_ready", {31'd0, if_ready}, 32'd0);
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_id_instr", id_instr, 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_id_imm", id_imm, 32'd0);
    chk("rst_stall_cnt", perf_stall_cnt, 32'd0);
    chk("rst_bp_cnt", perf_bp_cnt, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Single beat, 1-cycle latency.
    id_ready = 1'b1;
    send(32'h00500093, 32'h1000, 32'h00000005, 3'(FMT_I), 1'b0);
    if_valid = 1'b0;
    @(negedge clk);
    chk("latency_id_valid", {31'd0, id_valid}, 32'd1);
    chk("addi_imm", id_imm, 32'h00000005);
    chk("addi_fmt", {29'd0, 3'(id_fmt)}, 32'd1);
    @(posedge clk); #1;

    send(32'hFE208EE3, 32'h1004, 32'hFFFFFFFC, 3'(FMT_B), 1'b0);
    idle(2);

    // Skid: three back-to-back beats against a stalled consumer.
    id_ready = 1'b0;
    send(32'h123452B7, 32'h1008, 32'h12345000, 3'(FMT_U), 1'b0);
    send(32'h0020A423, 32'h100C, 32'h00000008, 3'(FMT_S), 1'b0);
    present(32'hFF9FF0EF, 32'h1010, 32'hFFFFFFF8, 3'(FMT_J), 1'b0);
    @(negedge clk);
    chk("skid_if_ready_low", {31'd0, if_ready}, 32'd0);
    chk("skid_head_instr", id_instr, 32'h123452B7);
    @(posedge clk); #1;
    @(negedge clk);
    chk("skid_if_ready_held", {31'd0, if_ready}, 32'd0);
    @(posedge clk); #1;
    id_ready = 1'b1;
    wait_accept();
    idle(4);
    chk("skid_drain", sb_q.size(), 32'd0);

    // Load-use bubble on rs1.
    ex_load_valid = 1'b1; ex_load_rd = 5'd1;
    send(32'h002081B3, 32'h1014, 32'h00000000, 3'(FMT_R), 1'b0);
    if_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hazard_bubble", {31'd0, id_valid}, 32'd0);
    end
    @(posedge clk); #1;
    ex_load_valid = 1'b0;
    @(negedge clk);
    chk("hazard_release", {31'd0, id_valid}, 32'd1);
    chk("stall_cnt", perf_stall_cnt, EXP_STALL);
    @(posedge clk); #1;

    // Load rd matches the rs1 field bits of a U-type, which reads no register.
    ex_load_valid = 1'b1; ex_load_rd = 5'd8;
    send(32'h123452B7, 32'h1018, 32'h12345000, 3'(FMT_U), 1'b0);
    if_valid = 1'b0;
    @(negedge clk);
    chk("u_no_hazard", {31'd0, id_valid}, 32'd1);
    @(posedge clk); #1;
    ex_load_valid = 1'b0; ex_load_rd = 5'd0;

    // Illegal opcode held under backpressure.
    id_ready = 1'b0;
    send(32'h0000007F, 32'h101C, 32'h00000000, 3'(FMT_NONE), 1'b1);
    if_valid = 1'b0;
    @(negedge clk);
    bp0 = perf_bp_cnt;
    chk("illegal_flag", {31'd0, id_illegal}, 32'd1);
    repeat (4) @(negedge clk);
    chk("bp_cnt_delta", perf_bp_cnt - bp0, EXP_BP);
    @(posedge clk); #1;
    id_ready = 1'b1;
    idle(2);

    // Flush in FULL_SKID with a beat waiting on the input.
    id_ready = 1'b0;
    send(32'hFFF12083, 32'h1020, 32'hFFFFFFFF, 3'(FMT_I), 1'b0);
    send(32'h00001517, 32'h1024, 32'h00001000, 3'(FMT_U), 1'b0);
    present(32'h00500093, 32'h1028, 32'h00000005, 3'(FMT_I), 1'b0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; if_valid = 1'b0;
    @(negedge clk);
    chk("flush_skid_id_valid", {31'd0, id_valid}, 32'd0);
    chk("flush_skid_if_ready", {31'd0, if_ready}, 32'd1);
    @(posedge clk); #1;
    id_ready = 1'b1;
    idle(3);

    // Flush in FULL while a beat is being accepted: that beat must be dropped.
    id_ready = 1'b0;
    send(32'h123452B7, 32'h102C, 32'h12345000, 3'(FMT_U), 1'b0);
    present(32'hFF9FF0EF, 32'h1030, 32'hFFFFFFF8, 3'(FMT_J), 1'b0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; if_valid = 1'b0;
    @(negedge clk);
    chk("flush_accept_id_valid", {31'd0, id_valid}, 32'd0);
    @(posedge clk); #1;
    id_ready = 1'b1;
    idle(3);

    // Reset mid-operation drops the buffered beat.
    id_ready = 1'b0;
    send(32'h00500093, 32'h1034, 32'h00000005, 3'(FMT_I), 1'b0);
    if_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("midrst_id_instr", id_instr, 32'd0);
    id_ready = 1'b1;
    idle(4);
    chk("final_drain", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
